// File: rtl/knn_pkg.sv
// Shared definitions for the KNN bit-serial datapath.
//   B            coordinate width in bits
//   IDW          reference identifier width
//   coord_code_e coordinate select code carried on the BDU bus
//   feeder_state_e  stream feeder FSM states
//   point_t      one 3-D point {x, y, z}
//   pick_bit     selects bit j of the coordinate named by a code
package knn_pkg;

  localparam int B   = 32;
  localparam int IDW = 16;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    X    = 2'b01,
    Y    = 2'b10,
    Z    = 2'b11
  } coord_code_e;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    WAIT_DONE,
    REPORT
  } feeder_state_e;

  typedef struct packed {
    logic [B-1:0] x;
    logic [B-1:0] y;
    logic [B-1:0] z;
  } point_t;

  function automatic logic pick_bit(input point_t p, input coord_code_e c,
                                    input logic [$clog2(B)-1:0] j);
    logic bit_sel;
    unique case (c)
      X:       bit_sel = p.x[j];
      Y:       bit_sel = p.y[j];
      Z:       bit_sel = p.z[j];
      default: bit_sel = 1'b0;
    endcase
    return bit_sel;
  endfunction

endpackage

// File: rtl/bdu_stream_feeder_if.sv
// Handshake and bus signals around the BDU stream feeder.
//   query load : q_load, q_x/q_y/q_z
//   reference  : in_valid/in_ready, r_x/r_y/r_z, r_id
//   BDU bus    : bdu_clr, valid, q_bit, r_bit, code, b, terminate, done
//   result     : res_valid/res_ready, res_id, res_early, res_beats
// Modport master is the feeder's view; slave is the environment's view.
interface bdu_stream_feeder_if #(
  parameter int B   = 32,
  parameter int IDW = 16
);

  localparam int BW = $clog2(B);
  localparam int CW = $clog2(3*B+1);

  logic           q_load;
  logic [B-1:0]   q_x;
  logic [B-1:0]   q_y;
  logic [B-1:0]   q_z;

  logic           in_valid;
  logic           in_ready;
  logic [B-1:0]   r_x;
  logic [B-1:0]   r_y;
  logic [B-1:0]   r_z;
  logic [IDW-1:0] r_id;

  logic           bdu_clr;
  logic           valid;
  logic           q_bit;
  logic           r_bit;
  logic [1:0]     code;
  logic [BW-1:0]  b;
  logic           terminate;
  logic           done;

  logic           res_valid;
  logic           res_ready;
  logic [IDW-1:0] res_id;
  logic           res_early;
  logic [CW-1:0]  res_beats;

  modport master (
    input  q_load, q_x, q_y, q_z,
    input  in_valid, r_x, r_y, r_z, r_id,
    output in_ready,
    output bdu_clr, valid, q_bit, r_bit, code, b,
    input  terminate, done,
    output res_valid, res_id, res_early, res_beats,
    input  res_ready
  );

  modport slave (
    output q_load, q_x, q_y, q_z,
    output in_valid, r_x, r_y, r_z, r_id,
    input  in_ready,
    input  bdu_clr, valid, q_bit, r_bit, code, b,
    output terminate, done,
    input  res_valid, res_id, res_early, res_beats,
    output res_ready
  );

endinterface

// File: rtl/bdu_stream_feeder_interleaver.sv
// bit_interleaver: combinational beat mux for the BDU stream.
//   en     high while streaming; all outputs are 0 otherwise
//   k      beat index 0..3B-1
//   qry    query point
//   rfr    reference point
//   q_bit  query bit of the current beat
//   r_bit  reference bit of the current beat
//   code   coordinate select (x, y, z rotating per beat)
//   b      bits processed including the current one, wrapping at 2^BW
module bit_interleaver
  import knn_pkg::*;
#(
  parameter int CW = $clog2(3*B+1),
  parameter int BW = $clog2(B)
) (
  input  logic          en,
  input  logic [CW-1:0] k,
  input  point_t        qry,
  input  point_t        rfr,
  output logic          q_bit,
  output logic          r_bit,
  output coord_code_e   code,
  output logic [BW-1:0] b
);

  // grp is the bit group (one x,y,z triple per group), rem the slot in it.
  logic [CW-1:0] grp;
  logic [CW-1:0] rem;
  logic [BW-1:0] j;
  logic          in_range;

  assign grp      = k / CW'(3);
  assign rem      = k - grp * CW'(3);
  assign j        = BW'(CW'(B - 1) - grp);
  assign in_range = en && (grp < CW'(B));

  always_comb begin
    code  = NONE;
    q_bit = 1'b0;
    r_bit = 1'b0;
    b     = '0;
    if (in_range) begin
      if (rem == CW'(0))      code = X;
      else if (rem == CW'(1)) code = Y;
      else                    code = Z;
      q_bit = pick_bit(qry, code, j);
      r_bit = pick_bit(rfr, code, j);
      // Truncation is intentional: the final group reads 0 when B is 2^n.
      b     = BW'(grp + CW'(1));
    end
  end

endmodule

// File: rtl/bdu_stream_feeder.sv
// bdu_stream_feeder: bit-serial transmitter feeding the BDU.
// Holds a query point, accepts one reference at a time, clears the BDU,
// streams query/reference bits MSB-first interleaved x,y,z, stops early on
// terminate or waits for done, then reports the outcome.
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  feeder side of bdu_stream_feeder_if (query load, reference
//        handshake, BDU bus, result handshake)
module bdu_stream_feeder #(
  parameter int B   = knn_pkg::B,
  parameter int IDW = knn_pkg::IDW
) (
  input  logic                clk,
  input  logic                rst,
  bdu_stream_feeder_if.master bus
);

  import knn_pkg::*;

  localparam int            BW   = $clog2(B);
  localparam int            CW   = $clog2(3*B+1);
  localparam logic [CW-1:0] LAST = CW'(3*B - 1);
  localparam logic [CW-1:0] FULL = CW'(3*B);

  feeder_state_e  state;
  feeder_state_e  state_n;
  logic [CW-1:0]  k;
  point_t         qry;
  point_t         rfr;
  logic [IDW-1:0] id_q;
  logic           early_q;
  logic [CW-1:0]  beats_q;
  // Low through reset and the first edge after release, so in_ready
  // stays 0 until the feeder is actually running.
  logic           run_q;

  logic           accept_q;
  logic           accept_r;
  logic           streaming;
  coord_code_e    code_w;

  assign accept_q  = run_q && (state == IDLE) && bus.q_load;
  assign accept_r  = run_q && (state == IDLE) && bus.in_valid;
  assign streaming = (state == STREAM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      run_q   <= 1'b0;
      k       <= '0;
      qry     <= '0;
      rfr     <= '0;
      id_q    <= '0;
      early_q <= 1'b0;
      beats_q <= '0;
    end else begin
      state <= state_n;
      run_q <= 1'b1;
      if (accept_q) qry <= {bus.q_x, bus.q_y, bus.q_z};
      if (accept_r) begin
        rfr  <= {bus.r_x, bus.r_y, bus.r_z};
        id_q <= bus.r_id;
      end
      unique case (state)
        CLEAR:  k <= '0;
        STREAM: begin
          k <= k + CW'(1);
          if (bus.terminate) begin
            early_q <= 1'b1;
            beats_q <= k + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.done || bus.terminate) begin
            early_q <= bus.terminate;
            beats_q <= FULL;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.bdu_clr   = 1'b0;
    bus.valid     = 1'b0;
    bus.res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = run_q;
        if (accept_r) state_n = CLEAR;
      end
      CLEAR: begin
        bus.bdu_clr = 1'b1;
        state_n     = STREAM;
      end
      STREAM: begin
        bus.valid = 1'b1;
        // terminate wins even on the last beat, skipping WAIT_DONE.
        if (bus.terminate)  state_n = REPORT;
        else if (k == LAST) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.done || bus.terminate) state_n = REPORT;
      end
      REPORT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  bit_interleaver #(
    .CW (CW),
    .BW (BW)
  ) u_interleaver (
    .en    (streaming),
    .k     (k),
    .qry   (qry),
    .rfr   (rfr),
    .q_bit (bus.q_bit),
    .r_bit (bus.r_bit),
    .code  (code_w),
    .b     (bus.b)
  );

  assign bus.code      = code_w;
  assign bus.res_id    = id_q;
  assign bus.res_early = early_q;
  assign bus.res_beats = beats_q;

endmodule

// File: tb/tb_bdu_stream_feeder.sv
// Testbench for bdu_stream_feeder: a table of reference transactions with
// hand-computed outcomes, a small BDU model answering terminate/done, and
// hand-written sequences for back-pressure, back-to-back and reset.
module tb_bdu_stream_feeder;

  localparam int B   = 32;
  localparam int IDW = 16;
  localparam int NB  = 3*B;
  localparam int NV  = 6;

  typedef struct {
    logic [31:0] qx, qy, qz;
    logic [31:0] rx, ry, rz;
    logic [15:0] id;
    bit          qload;
    bit          midq;
    int          term_beat;
    int          done_dly;
    bit          term_wait;
    int          hold;
    bit          exp_early;
    int          exp_beats;
    int          exp_wait;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bdu_stream_feeder_if #(.B(B), .IDW(IDW)) bus ();

  bdu_stream_feeder #(.B(B), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] cq_x, cq_y, cq_z;
  logic        lq [NB];
  logic        lr [NB];
  logic [1:0]  lc [NB];
  logic [4:0]  lb [NB];
  vec_t        vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] qx, qy, qz, rx, ry, rz,
                              input logic [15:0] id, input bit qload, midq,
                              input int term_beat, done_dly, input bit term_wait,
                              input int hold, input bit exp_early,
                              input int exp_beats, exp_wait);
    vec_t v;
    v.qx = qx; v.qy = qy; v.qz = qz;
    v.rx = rx; v.ry = ry; v.rz = rz;
    v.id = id; v.qload = qload; v.midq = midq;
    v.term_beat = term_beat; v.done_dly = done_dly; v.term_wait = term_wait;
    v.hold = hold; v.exp_early = exp_early;
    v.exp_beats = exp_beats; v.exp_wait = exp_wait;
    return v;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the CLEAR negedge.
  task automatic offer(input vec_t v);
    chk("offer_in_ready", 32'(bus.in_ready), 1);
    bus.r_x = v.rx; bus.r_y = v.ry; bus.r_z = v.rz; bus.r_id = v.id;
    bus.in_valid = 1'b1;
    if (v.qload) begin
      bus.q_x = v.qx; bus.q_y = v.qy; bus.q_z = v.qz;
      bus.q_load = 1'b1;
      cq_x = v.qx; cq_y = v.qy; cq_z = v.qz;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.q_load   = 1'b0;
  endtask

  // Called at the CLEAR negedge; returns at the first REPORT negedge.
  task automatic stream(input vec_t v);
    int beats = 0;
    int waitc = 0;
    int errs  = 0;
    bit got   = 0;
    int g, s, j, k;
    logic qe, re;
    logic [1:0] ce;
    logic [4:0] be;
    chk("clear_cycle", 32'({bus.bdu_clr, bus.valid}), 32'h2);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.terminate = 1'b0;
      bus.done      = 1'b0;
      bus.q_load    = 1'b0;
      if (cyc == 0) chk("first_beat_valid", 32'(bus.valid), 1);
      if (bus.res_valid) begin
        got = 1;
        break;
      end
      if (bus.valid) begin
        k = beats;
        if (k == 0) chk("clr_one_cycle", 32'(bus.bdu_clr), 0);
        if (k < NB) begin
          g = k / 3; s = k % 3; j = B - 1 - g;
          case (s)
            0:       begin qe = cq_x[j]; re = v.rx[j]; end
            1:       begin qe = cq_y[j]; re = v.ry[j]; end
            default: begin qe = cq_z[j]; re = v.rz[j]; end
          endcase
          ce = 2'(s + 1);
          be = 5'((g + 1) % 32);
          if (bus.q_bit !== qe || bus.r_bit !== re || bus.code !== ce || bus.b !== be) errs++;
          lq[k] = bus.q_bit; lr[k] = bus.r_bit; lc[k] = bus.code; lb[k] = bus.b;
        end else begin
          errs++;
        end
        beats++;
        if (k == v.term_beat) bus.terminate = 1'b1;
        if (v.midq && k == 10) begin
          bus.q_load = 1'b1;
          bus.q_x = ~cq_x; bus.q_y = ~cq_y; bus.q_z = ~cq_z;
        end
      end else if (beats > 0) begin
        waitc++;
        if (waitc == v.done_dly) begin
          bus.done      = 1'b1;
          bus.terminate = v.term_wait;
        end
      end
    end
    if (!got) begin
      chk("result_timeout", 0, 1);
    end else begin
      chk("beat_data_errors", 32'(errs), 0);
      chk("beats_seen", 32'(beats), 32'(v.exp_beats));
      chk("wait_done_cycles", 32'(waitc), 32'(v.exp_wait));
      chk("res_id", 32'(bus.res_id), 32'(v.id));
      chk("res_early", 32'(bus.res_early), 32'(v.exp_early));
      chk("res_beats", 32'(bus.res_beats), 32'(v.exp_beats));
      chk("report_valid_low", 32'(bus.valid), 0);
    end
  endtask

  task automatic hold_release(input int hold);
    logic [15:0] id0;
    logic        e0;
    logic [6:0]  bt0;
    int          unst = 0;
    id0 = bus.res_id; e0 = bus.res_early; bt0 = bus.res_beats;
    repeat (hold) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_id !== id0 || bus.res_early !== e0 ||
          bus.res_beats !== bt0 || bus.in_ready !== 1'b0) unst++;
    end
    if (hold > 0) chk("hold_stable", 32'(unst), 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("idle_res_valid", 32'(bus.res_valid), 0);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t va, vb, vr;
    int   unst, cnt;
    logic [15:0] id0;

    bus.q_load = 0; bus.q_x = 0; bus.q_y = 0; bus.q_z = 0;
    bus.in_valid = 0; bus.r_x = 0; bus.r_y = 0; bus.r_z = 0; bus.r_id = 0;
    bus.terminate = 0; bus.done = 0; bus.res_ready = 0;
    cq_x = 0; cq_y = 0; cq_z = 0;

    //            qx            qy            qz            rx            ry            rz            id        ql md term dly tw hold early beats wait
    vt[0] = mk(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFF0, 32'h0000FFF0, 32'h0000FFF0, 16'h0A01, 1, 0, -1, 2, 0, 0, 0, 96, 2);
    vt[1] = mk(32'h0,        32'h0,        32'h0,        32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 16'h0B02, 0, 0, 50, 0, 0, 5, 1, 51, 0);
    vt[2] = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000001, 16'h0C03, 1, 0, 95, 0, 0, 0, 1, 96, 0);
    vt[3] = mk(32'h0,        32'h0,        32'h0,        32'h80000001, 32'h7FFFFFFE, 32'hC3C3C3C3, 16'h0D04, 0, 0, -1, 1, 1, 0, 1, 96, 1);
    vt[4] = mk(32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98, 32'h11111111, 32'h22222222, 32'h33333333, 16'h0E05, 1, 1, -1, 3, 0, 0, 0, 96, 3);
    vt[5] = mk(32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 16'h0F06, 0, 0,  0, 0, 0, 0, 1, 1, 0);

    // Reset state and in_ready release timing.
    #2;
    chk("rst_outputs", 32'({bus.in_ready, bus.bdu_clr, bus.valid, bus.q_bit, bus.r_bit,
                            bus.code, bus.b, bus.res_valid, bus.res_early}), 0);
    chk("rst_res_fields", 32'({bus.res_id, bus.res_beats}), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("in_ready_before_edge", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_edge", 32'(bus.in_ready), 1);

    for (int i = 0; i < NV; i++) begin
      offer(vt[i]);
      stream(vt[i]);
      if (i == 0) begin
        chk("basic_b47_qr", 32'({lq[47], lr[47]}), 32'h0);
        chk("basic_b48_qr", 32'({lq[48], lr[48]}), 32'h3);
        chk("basic_b59_qr", 32'({lq[59], lr[59]}), 32'h3);
        chk("basic_b84_qr", 32'({lq[84], lr[84]}), 32'h2);
        chk("basic_b95_qr", 32'({lq[95], lr[95]}), 32'h2);
        chk("basic_codes", 32'({lc[0], lc[1], lc[2], lc[3]}), 32'b01_10_11_01);
        chk("basic_b_first", 32'(lb[0]), 1);
        chk("basic_b_92", 32'(lb[92]), 31);
        chk("basic_b_last", 32'(lb[95]), 0);
      end
      hold_release(vt[i].hold);
    end

    // Back-pressure with a second reference waiting.
    va = mk(32'hF0F0F0F0, 32'h0F0F0F0F, 32'hAAAA5555, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 16'h1111, 1, 0, 20, 0, 0, 0, 1, 21, 0);
    vb = mk(32'h0, 32'h0, 32'h0, 32'h76543210, 32'h0000FFFF, 32'hFFFF0000, 16'h2222, 0, 0, -1, 2, 0, 0, 0, 96, 2);
    offer(va);
    stream(va);
    id0 = bus.res_id;
    bus.r_x = vb.rx; bus.r_y = vb.ry; bus.r_z = vb.rz; bus.r_id = vb.id;
    bus.in_valid = 1'b1;
    unst = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_id !== id0 ||
          bus.res_beats !== 7'd21 || bus.bdu_clr !== 1'b0) unst++;
    end
    chk("b2b_hold_stable", 32'(unst), 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("b2b_idle_gap", 32'({bus.in_ready, bus.bdu_clr, bus.res_valid}), 32'h4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_clr_2_after", 32'(bus.bdu_clr), 1);
    stream(vb);
    hold_release(0);

    // Reset during beat 30.
    vr = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h3333, 1, 0, -1, 0, 0, 0, 0, 0, 0);
    offer(vr);
    cnt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (bus.valid) cnt++;
      if (cnt == 31) break;
    end
    chk("rst_reached_beat30", 32'(cnt), 31);
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({bus.in_ready, bus.bdu_clr, bus.valid, bus.q_bit, bus.r_bit,
                                bus.code, bus.b, bus.res_valid, bus.res_early}), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'({bus.in_ready, bus.res_valid}), 32'h2);
    unst = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.valid !== 1'b0 || bus.bdu_clr !== 1'b0) unst++;
    end
    chk("rst_no_stale_result", 32'(unst), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bdu_stream_feeder.md
# bdu_stream_feeder

Bit-serial transmitter that drives the BDU (bit-serial distance unit). It holds one query point and accepts reference points one at a time. For each reference it clears the BDU, then streams the query and reference coordinates MSB-first, interleaved x,y,z, one bit pair per cycle. It aborts the stream as soon as the BDU signals `terminate`, waits for `done` otherwise, and reports the outcome per reference to the KNN control layer.

## Interface
- `B`, 32: coordinate width in bits.
- `IDW`, 16: reference identifier width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `q_load`  in  1  capture `q_x/q_y/q_z` (honoured only in IDLE).
- `q_x`, `q_y`, `q_z`  in  B each  query coordinates.
- `in_valid`  in  1  reference offered.
- `in_ready`  out  1  feeder accepts a reference.
- `r_x`, `r_y`, `r_z`  in  B each  reference coordinates.
- `r_id`  in  IDW  reference identifier.
- `bdu_clr`  out  1  one-cycle clear pulse to the BDU.
- `valid`  out  1  beat valid to the BDU.
- `q_bit`, `r_bit`  out  1 each  current query and reference bits.
- `code`  out  2  coordinate select: 01 x, 10 y, 11 z; 00 when idle.
- `b`  out  $clog2(B)  bits processed including the current one, modulo 2^$clog2(B).
- `terminate`  in  1  BDU partial distance exceeded threshold.
- `done`  in  1  BDU finished the full distance.
- `res_valid`  out  1  result available; held until `res_ready`.
- `res_ready`  in  1  consumer takes the result.
- `res_id`  out  IDW  identifier of the reported reference.
- `res_early`  out  1  1 = stream aborted by `terminate`.
- `res_beats`  out  $clog2(3B+1)  number of beats sent with `valid`=1.

## Operation
- FSM states: IDLE, CLEAR, STREAM, WAIT_DONE, REPORT.
- IDLE
  - `in_ready`=1.
  - `q_load`=1 captures the query registers.
  - `in_valid`=1 captures the reference and `r_id`, then goes to CLEAR.
  - If `q_load` and `in_valid` are both high in the same cycle, the new query applies to that reference.
- CLEAR: `bdu_clr`=1 and `valid`=0 for one cycle, then STREAM with beat counter k=0.
- STREAM, beat k (0..3B-1):
  - `valid`=1.
  - `code` = {01,10,11}[k mod 3].
  - Bit index j = B-1-(k/3); `q_bit`/`r_bit` = selected coordinate bit j.
  - `b` = (k/3+1) truncated, so the final group carries 0 when B is a power of two.
- Transitions out of STREAM:
  - `terminate` sampled high → REPORT with `res_early`=1 and `res_beats`=k+1.
  - After beat 3B-1 with no `terminate` → WAIT_DONE.
- WAIT_DONE: `valid`=0.
  - `done` → REPORT with early=0 and beats=3B.
  - `terminate` → early=1. If both are high, early=1.
- REPORT: `res_valid`=1 and result fields stable. On `res_ready` → IDLE.
- `q_load` and `in_valid` are ignored outside IDLE. Query registers persist across references.
- Coordinates are treated as raw unsigned bit vectors; no arithmetic is performed.

## Timing
- Reset: all outputs 0, state IDLE, query and reference registers 0. `in_ready` rises on the first edge after reset release.
- Reset asserted mid-stream drops `valid`, `bdu_clr` and `res_valid` immediately (asynchronously). No result is reported for the aborted reference.
- Accept at edge t: `bdu_clr` during cycle t+1, first beat during cycle t+2, last beat during cycle t+3B+1.
- `terminate` high at the edge ending beat k: `valid`=0 in the next cycle and `res_valid`=1 from that cycle.
- `terminate` coinciding with the last beat: early=1, beats=3B, and WAIT_DONE is skipped.
- Earliest `done` response: REPORT the cycle after `done` is sampled.
- `res_valid` and `res_ready` high in the same cycle → back to IDLE next cycle. Minimum gap between references is one IDLE cycle.

## Structure
- Shared package `knn_pkg`: `B`, `coord_code_e` (NONE=00, X=01, Y=10, Z=11), FSM state enum, `point_t` struct {x,y,z}.
- Sub-module `bit_interleaver`: combinational mux from beat counter k and two `point_t` values to `q_bit`/`r_bit`/`code`/`b`.
- FSM, counters and handshakes stay in the top level.

## Test plan
- Basic stream:
  - Stimulus: query all coordinates 0x0000FFFF, reference all 0xFFF0; BDU model never terminates and asserts `done` two cycles after the last beat.
  - Required: 96 beats; codes cycle 01,10,11; beats 0–47 have q=r=0; beats 48–59 have q=r=1; beats 84–95 have q=1, r=0; `b` runs 1..31 then 0; result early=0, beats=96.
- Early terminate:
  - Stimulus: BDU model raises `terminate` at beat 50.
  - Required: `valid`=0 the next cycle; result early=1, beats=51, `res_id` matches.
- Simultaneous events:
  - `terminate` on beat 95 → early=1, beats=96, no WAIT_DONE cycle.
  - `done`+`terminate` together in WAIT_DONE → early=1.
- Back-pressure and back-to-back:
  - Stimulus: `res_ready` held low 5 cycles; a second reference offered during that time.
  - Required: result fields stable throughout; `in_ready`=0 until release; second stream's `bdu_clr` arrives 2 cycles after release.
- Query reload:
  - `q_load` mid-stream is ignored.
  - `q_load`+`in_valid` together in IDLE → the stream uses the new query bits.
- Reset mid-stream: `rst` low at beat 30 → all outputs 0 immediately; after release `in_ready`=1 and no stale `res_valid`.
